// File: rtl/id_stage_pkg.sv
// Shared definitions for the decode stage: opcodes, instruction field positions
// and the EX operand-select encoding.
package id_stage_pkg;

    localparam logic [5:0] OP_NOP = 6'h00;
    localparam logic [5:0] OP_ADD = 6'h01;
    localparam logic [5:0] OP_SUB = 6'h02;
    localparam logic [5:0] OP_LDW = 6'h23;
    localparam logic [5:0] OP_SDW = 6'h2B;

    localparam int OPC_LSB = 26;
    localparam int RS_LSB  = 21;
    localparam int RT_LSB  = 16;
    localparam int RD_LSB  = 11;

    // EX must treat FWD_MEM_LD as "take mem_data_from_mem".
    typedef enum logic [2:0] {
        FWD_REG     = 3'd0,
        FWD_EX      = 3'd1,
        FWD_MEM_ALU = 3'd2,
        FWD_MEM_LD  = 3'd3
    } fwd_e;

endpackage

// File: rtl/id_stage_reg_file.sv
// Register file: two combinational read ports, one write port, write-first
// bypass, r0 hardwired to zero.
module id_stage_reg_file #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);
    localparam int NREG = 1 << REG_AW;

    logic [DATA_W-1:0] mem_q [NREG];
    logic              wr_en_s;

    assign wr_en_s = we && (waddr != {REG_AW{1'b0}});

    // Storage update: cleared on reset, r0 never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_en_s) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read ports with same-cycle write bypass.
    always_comb begin
        rdata_a = {DATA_W{1'b0}};
        rdata_b = {DATA_W{1'b0}};
        if (raddr_a == {REG_AW{1'b0}}) begin
            rdata_a = {DATA_W{1'b0}};
        end else if (wr_en_s && (waddr == raddr_a)) begin
            rdata_a = wdata;
        end else begin
            rdata_a = mem_q[raddr_a];
        end
        if (raddr_b == {REG_AW{1'b0}}) begin
            rdata_b = {DATA_W{1'b0}};
        end else if (wr_en_s && (waddr == raddr_b)) begin
            rdata_b = wdata;
        end else begin
            rdata_b = mem_q[raddr_b];
        end
    end

endmodule

// File: rtl/id_stage.sv
// Decode stage: splits the instruction, reads operands, detects load-use hazards
// and registers operands plus precomputed forwarding selects into ID/EX.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr_in,
    input  logic              instr_vld,
    input  logic              flush_in,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall_out,
    output logic [DATA_W-1:0] imm_out,
    output logic [DATA_W-1:0] val_rs_out,
    output logic [DATA_W-1:0] val_rt_out,
    output logic [REG_AW-1:0] rwd_out,
    output logic [5:0]        opcode_out,
    output logic [2:0]        rs_fwd,
    output logic [2:0]        rt_fwd
);
    logic [5:0]        opcode_s;
    logic [REG_AW-1:0] rs_s, rt_s, rd_s, dest_s;
    logic              is_load_s, reads_rt_s, stall_s, issue_s;
    logic [DATA_W-1:0] rs_val_s, rt_val_s;

    logic [REG_AW-1:0] e1_rwd_q, e1_rwd_d, e2_rwd_q, e2_rwd_d;
    logic              e1_load_q, e1_load_d, e2_load_q, e2_load_d;

    logic [DATA_W-1:0] imm_q, imm_d, val_rs_q, val_rs_d, val_rt_q, val_rt_d;
    logic [REG_AW-1:0] rwd_q, rwd_d;
    logic [5:0]        opcode_q, opcode_d;
    logic [2:0]        rs_fwd_q, rs_fwd_d, rt_fwd_q, rt_fwd_d;

    // Younger producer (e1) wins over the older one (e2).
    function automatic logic [2:0] fwd_sel(input logic [REG_AW-1:0] src,
                                           input logic [REG_AW-1:0] e1_rwd,
                                           input logic [REG_AW-1:0] e2_rwd,
                                           input logic              e2_load);
        logic [2:0] sel;
        sel = FWD_REG;
        if (src == {REG_AW{1'b0}}) begin
            sel = FWD_REG;
        end else if (src == e1_rwd) begin
            sel = FWD_EX;
        end else if (src == e2_rwd) begin
            sel = e2_load ? FWD_MEM_LD : FWD_MEM_ALU;
        end else begin
            sel = FWD_REG;
        end
        return sel;
    endfunction

    assign opcode_s = instr_in[OPC_LSB +: 6];
    assign rs_s     = instr_in[RS_LSB +: REG_AW];
    assign rt_s     = instr_in[RT_LSB +: REG_AW];
    assign rd_s     = instr_in[RD_LSB +: REG_AW];

    id_stage_reg_file #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_reg_file (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_we),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (rs_s),
        .raddr_b (rt_s),
        .rdata_a (rs_val_s),
        .rdata_b (rt_val_s)
    );

    // Destination and operand-usage decode.
    always_comb begin
        dest_s     = rd_s;
        is_load_s  = 1'b0;
        reads_rt_s = 1'b1;
        case (opcode_s)
            OP_LDW: begin
                dest_s     = rt_s;
                is_load_s  = 1'b1;
                reads_rt_s = 1'b0;
            end
            OP_SDW, OP_NOP: dest_s = {REG_AW{1'b0}};
            default:        dest_s = rd_s;
        endcase
    end

    // Load-use hazard; flush suppresses it.
    always_comb begin
        stall_s = 1'b0;
        if (instr_vld && !flush_in && e1_load_q && (e1_rwd_q != {REG_AW{1'b0}})) begin
            stall_s = (rs_s == e1_rwd_q) || (reads_rt_s && (rt_s == e1_rwd_q));
        end else begin
            stall_s = 1'b0;
        end
        issue_s = instr_vld && !flush_in && !stall_s;
    end

    assign stall_out = stall_s;

    // ID/EX next values: issued instruction or a bubble; trackers shift.
    always_comb begin
        imm_d     = {DATA_W{1'b0}};
        val_rs_d  = {DATA_W{1'b0}};
        val_rt_d  = {DATA_W{1'b0}};
        rwd_d     = {REG_AW{1'b0}};
        opcode_d  = OP_NOP;
        rs_fwd_d  = FWD_REG;
        rt_fwd_d  = FWD_REG;
        e1_load_d = 1'b0;
        if (issue_s) begin
            imm_d     = {{(DATA_W-16){instr_in[15]}}, instr_in[15:0]};
            val_rs_d  = rs_val_s;
            val_rt_d  = rt_val_s;
            rwd_d     = dest_s;
            opcode_d  = opcode_s;
            rs_fwd_d  = fwd_sel(rs_s, e1_rwd_q, e2_rwd_q, e2_load_q);
            rt_fwd_d  = reads_rt_s ? fwd_sel(rt_s, e1_rwd_q, e2_rwd_q, e2_load_q) : FWD_REG;
            e1_load_d = is_load_s;
        end else begin
            opcode_d  = OP_NOP;
        end
        e1_rwd_d  = rwd_d;
        e2_rwd_d  = e1_rwd_q;
        e2_load_d = e1_load_q;
    end

    // ID/EX register and hazard trackers.
    always_ff @(posedge clk) begin
        if (rst) begin
            imm_q     <= {DATA_W{1'b0}};
            val_rs_q  <= {DATA_W{1'b0}};
            val_rt_q  <= {DATA_W{1'b0}};
            rwd_q     <= {REG_AW{1'b0}};
            opcode_q  <= OP_NOP;
            rs_fwd_q  <= FWD_REG;
            rt_fwd_q  <= FWD_REG;
            e1_rwd_q  <= {REG_AW{1'b0}};
            e1_load_q <= 1'b0;
            e2_rwd_q  <= {REG_AW{1'b0}};
            e2_load_q <= 1'b0;
        end else begin
            imm_q     <= imm_d;
            val_rs_q  <= val_rs_d;
            val_rt_q  <= val_rt_d;
            rwd_q     <= rwd_d;
            opcode_q  <= opcode_d;
            rs_fwd_q  <= rs_fwd_d;
            rt_fwd_q  <= rt_fwd_d;
            e1_rwd_q  <= e1_rwd_d;
            e1_load_q <= e1_load_d;
            e2_rwd_q  <= e2_rwd_d;
            e2_load_q <= e2_load_d;
        end
    end

    assign imm_out    = imm_q;
    assign val_rs_out = val_rs_q;
    assign val_rt_out = val_rt_q;
    assign rwd_out    = rwd_q;
    assign opcode_out = opcode_q;
    assign rs_fwd     = rs_fwd_q;
    assign rt_fwd     = rt_fwd_q;

endmodule
